// File: rtl/multi_glitch_filter_pkg.sv
// Shared defaults and counter-width helper for the multi-channel glitch filter.
package multi_glitch_filter_pkg;

    localparam int   DEF_WIDTH     = 4;
    localparam int   DEF_DEPTH     = 3;
    localparam logic DEF_RESET_VAL = 1'b0;

    // Counter only has to reach DEPTH-1; keep at least one bit for DEPTH of 1 or 2.
    function automatic int cnt_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/glitch_filter_chan.sv
// One glitch-filter channel: sample register, run counter, filtered output and edge events.
module glitch_filter_chan
    import multi_glitch_filter_pkg::*;
#(
    parameter int   DEPTH     = DEF_DEPTH,
    parameter logic RESET_VAL = DEF_RESET_VAL
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic sig_in,
    output logic sig_out,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W   = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH - 1);

    logic             s;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s       <= RESET_VAL;
            cnt     <= '0;
            sig_out <= RESET_VAL;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (enable) begin
                s <= sig_in;
                // Any sample matching the output restarts the run.
                if (s == sig_out) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    sig_out <= s;
                    cnt     <= '0;
                    rise    <= s;
                    fall    <= ~s;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_glitch_filter.sv
// WIDTH independent glitch-filter channels sharing clock, reset and sample strobe.
module multi_glitch_filter
    import multi_glitch_filter_pkg::*;
#(
    parameter int   WIDTH     = DEF_WIDTH,
    parameter int   DEPTH     = DEF_DEPTH,
    parameter logic RESET_VAL = DEF_RESET_VAL
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] sig_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        glitch_filter_chan #(
            .DEPTH     (DEPTH),
            .RESET_VAL (RESET_VAL)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .enable  (enable),
            .sig_in  (sig_in[i]),
            .sig_out (sig_out[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

endmodule

// File: tb/tb_multi_glitch_filter.sv
// Bench for multi_glitch_filter: three configurations checked against a sample-window model.
module tb_multi_glitch_filter;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] sin0;
    logic       sin1, sin2;
    logic [3:0] so0, ri0, fa0;
    logic       so1, ri1, fa1, so2, ri2, fa2;

    int checks = 0;
    int errs   = 0;

    always #5 clock = ~clock;

    multi_glitch_filter #(.WIDTH(4), .DEPTH(3), .RESET_VAL(1'b0)) d0 (
        .clock(clock), .reset(reset), .enable(enable), .sig_in(sin0),
        .sig_out(so0), .rise(ri0), .fall(fa0));
    multi_glitch_filter #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) d1 (
        .clock(clock), .reset(reset), .enable(enable), .sig_in(sin1),
        .sig_out(so1), .rise(ri1), .fall(fa1));
    multi_glitch_filter #(.WIDTH(1), .DEPTH(5), .RESET_VAL(1'b1)) d2 (
        .clock(clock), .reset(reset), .enable(enable), .sig_in(sin2),
        .sig_out(so2), .rise(ri2), .fall(fa2));

    // Model: output flips when the last DEPTH enabled samples all differ from it.
    int   mdep [6] = '{3, 3, 3, 3, 1, 5};
    logic mrv  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic mout [6];
    logic mrise[6];
    logic mfall[6];
    logic mhist[6][5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic in_bit(input int ch);
        if (ch < 4)  return sin0[ch];
        if (ch == 4) return sin1;
        return sin2;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 6; c++) begin
            mout[c]  = mrv[c];
            mrise[c] = 1'b0;
            mfall[c] = 1'b0;
            for (int k = 0; k < 5; k++) mhist[c][k] = mrv[c];
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 6; c++) begin
            mrise[c] = 1'b0;
            mfall[c] = 1'b0;
            if (enable) begin
                logic all_diff;
                all_diff = 1'b1;
                for (int k = 0; k < mdep[c]; k++)
                    if (mhist[c][k] == mout[c]) all_diff = 1'b0;
                if (all_diff) begin
                    mrise[c] = ~mout[c];
                    mfall[c] = mout[c];
                    mout[c]  = ~mout[c];
                end
                for (int k = 4; k > 0; k--) mhist[c][k] = mhist[c][k-1];
                mhist[c][0] = in_bit(c);
            end
        end
    endtask

    task automatic check_all(input string phase);
        logic [5:0] e_out, e_rise, e_fall;
        for (int c = 0; c < 6; c++) begin
            e_out[c]  = mout[c];
            e_rise[c] = mrise[c];
            e_fall[c] = mfall[c];
        end
        chk({phase, ".sig_out"}, 32'({so2, so1, so0}), 32'(e_out));
        chk({phase, ".rise"},    32'({ri2, ri1, ri0}), 32'(e_rise));
        chk({phase, ".fall"},    32'({fa2, fa1, fa0}), 32'(e_fall));
        chk({phase, ".no_both"}, 32'({ri2, ri1, ri0} & {fa2, fa1, fa0}), 32'd0);
    endtask

    // Called at a negedge with inputs already set; returns at the following negedge.
    task automatic cyc(input string phase);
        @(posedge clock);
        model_edge();
        #1;
        check_all(phase);
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        chk("reset.const_out", 32'({so2, so1, so0}), 32'(6'b100000));
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] pat;
        reset  = 1'b0;
        enable = 1'b0;
        sin0   = 4'b0000;
        sin1   = 1'b0;
        sin2   = 1'b1;
        @(negedge clock);
        pulse_reset();
        enable = 1'b1;

        // Basic rise on channel 0
        sin0 = 4'b0001;
        repeat (5) cyc("basic");
        chk("basic.out", 32'(so0), 32'(4'b0001));

        // Glitch pattern on channel 1, then a qualifying run
        pat = 16'b0000_0001_1011_0111;
        for (int i = 8; i >= 0; i--) begin
            sin0[1] = pat[i];
            cyc("glitch");
        end
        repeat (2) cyc("glitch_tail");

        // Enable gating on channel 2: run is preserved across disabled edges
        sin0[2] = 1'b1;
        repeat (2) cyc("gate_on");
        enable = 1'b0;
        repeat (5) cyc("gate_off");
        enable = 1'b1;
        repeat (3) cyc("gate_resume");

        // Simultaneous rise and fall
        sin0 = 4'b0101;
        repeat (5) cyc("simul_a");
        sin0 = 4'b1010;
        repeat (5) cyc("simul_b");
        chk("simul.out", 32'(so0), 32'(4'b1010));

        // Reset in the middle of a run
        sin0 = 4'b0000;
        repeat (5) cyc("mid_pre");
        sin0[0] = 1'b1;
        repeat (2) cyc("mid_run");
        pulse_reset();
        repeat (4) cyc("mid_post");

        // Serial pattern on the DEPTH=1 and DEPTH=5 instances
        pat = 16'b0001_1101_0111_1101;
        for (int i = 15; i >= 0; i--) begin
            sin1 = pat[i];
            sin2 = pat[i];
            cyc("serial");
        end
        repeat (3) cyc("serial_tail");

        // Randomised run with occasional disables and resets
        for (int n = 0; n < 600; n++) begin
            enable = ($urandom_range(7) != 0);
            for (int c = 0; c < 4; c++)
                if ($urandom_range(3) == 0) sin0[c] = ~sin0[c];
            if ($urandom_range(2) == 0) sin1 = ~sin1;
            if ($urandom_range(5) == 0) sin2 = ~sin2;
            if ($urandom_range(99) == 0) pulse_reset();
            cyc("rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
